// File: rtl/ones_counter_pipe_pkg.sv
// Sizing helpers for the pipelined ones counter.
// The top and its adder-tree levels use these to derive level widths and operand counts.
package ones_counter_pipe_pkg;

  localparam int DEF_N      = 15;
  localparam int DEF_THRESH = 8;
  localparam int DEF_ACC_W  = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_CNT_W = clog2(DEF_N + 1);

  // Operands entering tree level k: ceil(n / 2^k), odd leftovers carried forward.
  function automatic int level_cnt(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

  // Width of a level-k partial sum, which can reach 2^k.
  function automatic int level_w(input int k);
    return clog2((1 << k) + 1);
  endfunction

endpackage

// File: rtl/ones_counter_pipe_level.sv
// One registered level of the pairwise adder tree.
// An odd leftover operand is zero-extended and passed through unchanged.
module popcount_level #(
  parameter int IN_CNT = 2,
  parameter int IN_W   = 1,
  parameter int OUT_W  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  input  logic [IN_CNT*IN_W-1:0]           ops,
  output logic                             sum_valid,
  output logic [((IN_CNT+1)/2)*OUT_W-1:0]  sums
);

  localparam int OUT_CNT = (IN_CNT + 1) / 2;

  logic [OUT_CNT*OUT_W-1:0] sums_next;

  genvar gi;
  generate
    for (gi = 0; gi < IN_CNT / 2; gi++) begin : g_pair
      assign sums_next[gi*OUT_W +: OUT_W] = OUT_W'(ops[2*gi*IN_W +: IN_W])
                                          + OUT_W'(ops[(2*gi+1)*IN_W +: IN_W]);
    end
    if (IN_CNT % 2 == 1) begin : g_odd
      assign sums_next[(OUT_CNT-1)*OUT_W +: OUT_W] = OUT_W'(ops[(IN_CNT-1)*IN_W +: IN_W]);
    end
  endgenerate

  // Sums only load with a valid operand set, so the final count holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_valid <= 1'b0;
      sums      <= '0;
    end else begin
      sum_valid <= op_valid;
      if (op_valid) sums <= sums_next;
    end
  end

endmodule

// File: rtl/ones_counter_pipe.sv
// Pipelined ones counter: input register, clog2(N) registered adder levels,
// threshold flag and a saturating running accumulator of the emerging counts.
import ones_counter_pipe_pkg::*;

module ones_counter_pipe #(
  parameter int N      = DEF_N,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int THRESH = DEF_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             ge_thresh,
  output logic [ACC_W-1:0] acc,
  output logic             acc_sat
);

  localparam int LEVELS = clog2(N);
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  logic [N-1:0] data_reg;
  logic         valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) data_reg <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : lvl
      localparam int IN_CNT = level_cnt(N, gi);
      localparam int IN_W   = level_w(gi);
      // The last level is sized straight to CNT_W; its value never exceeds N.
      localparam int OUT_W  = (gi == LEVELS - 1) ? CNT_W : level_w(gi + 1);

      logic [IN_CNT*IN_W-1:0]             ops;
      logic                               ops_valid;
      logic [((IN_CNT+1)/2)*OUT_W-1:0]    sums;
      logic                               sums_valid;

      if (gi == 0) begin : g_src
        assign ops       = data_reg;
        assign ops_valid = valid_reg;
      end else begin : g_src
        assign ops       = lvl[gi-1].sums;
        assign ops_valid = lvl[gi-1].sums_valid;
      end

      popcount_level #(
        .IN_CNT (IN_CNT),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W)
      ) u_level (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (ops_valid),
        .ops       (ops),
        .sum_valid (sums_valid),
        .sums      (sums)
      );

      if (gi == LEVELS - 1) begin : g_out
        assign count     = sums;
        assign out_valid = sums_valid;
      end
    end
  endgenerate

  assign ge_thresh = out_valid && (count >= THRESH_V);

  logic [ACC_W:0] acc_sum;
  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(count);

  // Clear beats accumulate; the carry-out of the widened sum marks a clip.
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      acc     <= '0;
      acc_sat <= 1'b0;
    end else if (out_valid && acc_en) begin
      if (acc_sum[ACC_W]) begin
        acc     <= '1;
        acc_sat <= 1'b1;
      end else begin
        acc <= acc_sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ones_counter_pipe.sv
// Directed bench for ones_counter_pipe at N=15, ACC_W=8, THRESH=8 (latency 5).
// Inputs change 1 ns after each rising edge and outputs are checked there too.
module tb_ones_counter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [14:0] in_data;
  logic        acc_en;
  logic        acc_clr;
  logic        out_valid;
  logic [3:0]  count;
  logic        ge_thresh;
  logic [7:0]  acc;
  logic        acc_sat;

  int checks = 0;
  int errors = 0;

  ones_counter_pipe #(
    .N      (15),
    .CNT_W  (4),
    .ACC_W  (8),
    .THRESH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .count     (count),
    .ge_thresh (ge_thresh),
    .acc       (acc),
    .acc_sat   (acc_sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reset mid-stream table: even cycles carry samples, rst pulses on cycle 5.
  logic [14:0] t6_d   [20] = '{15'h0007, 15'h7FFF, 15'h000F, 15'h7FFF, 15'h003F,
                               15'h7FFF, 15'h01FF, 15'h7FFF, 15'h0003, 15'h7FFF,
                               15'h7FFF, 15'h7FFF, 15'h0000, 15'h7FFF, 15'h00FF,
                               15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF};
  logic        t6_v   [20] = '{1,0,1,0,1, 0,1,0,1,0, 1,0,1,0,1, 0,0,0,0,0};
  logic        t6_eov [20] = '{0,0,0,0,1, 0,0,0,0,0, 1,0,1,0,1, 0,1,0,1,0};
  int          t6_ecnt[20] = '{5,5,5,5,3, 0,0,0,0,0, 9,9,2,2,15, 15,0,0,8,8};
  logic        t6_ege [20] = '{0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,1, 0,0,0,1,0};

  logic [14:0] t3_d   [4] = '{15'h0000, 15'h7FFF, 15'h00FF, 15'h007F};
  int          t3_cnt [4] = '{0, 15, 8, 7};
  logic        t3_ge  [4] = '{0, 1, 1, 0};

  initial begin
    int exp_acc;

    // 1: reset held with a full sample presented; nothing may escape.
    rst = 1'b1; in_valid = 1'b1; in_data = 15'h7FFF; acc_en = 1'b0; acc_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_ge", ge_thresh, 0);
      check("rst_acc", acc, 0);
      check("rst_acc_sat", acc_sat, 0);
    end
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("post_rst_quiet", out_valid, 0);
    end

    // 2: one-hot walk, one sample per cycle.
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 15);
      in_data  = (c < 15) ? 15'(1 << c) : 15'h0;
      step();
      if (c >= 4 && c < 19) begin
        $display("onehot bit=%0d out_valid=%0b count=%0d ge=%0b", c - 4, out_valid, count, ge_thresh);
        check("onehot_valid", out_valid, 1);
        check("onehot_count", count, 1);
        check("onehot_ge", ge_thresh, 0);
      end else begin
        check("onehot_idle_valid", out_valid, 0);
        check("onehot_idle_count", count, (c < 4) ? 0 : 1);
      end
    end

    // 3: back-to-back boundary patterns.
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? t3_d[c] : 15'h0;
      step();
      if (c >= 4 && c < 8) begin
        $display("b2b idx=%0d out_valid=%0b count=%0d ge=%0b", c - 4, out_valid, count, ge_thresh);
        check("b2b_valid", out_valid, 1);
        check("b2b_count", count, t3_cnt[c-4]);
        check("b2b_ge", ge_thresh, t3_ge[c-4]);
      end else if (c == 8) begin
        check("b2b_hold_count", count, 7);
        check("b2b_idle_ge", ge_thresh, 0);
      end
    end

    // 4: accumulate full samples into saturation, then clear.
    acc_en = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 18);
      in_data  = 15'h7FFF;
      step();
      if (c >= 5 && c < 23) begin
        exp_acc = ((c - 4) * 15 > 255) ? 255 : (c - 4) * 15;
        $display("acc sample=%0d acc=%0d acc_sat=%0b", c - 4, acc, acc_sat);
        check("acc_value", acc, exp_acc);
        check("acc_sat", acc_sat, (c - 5 >= 17) ? 1 : 0);
      end
    end
    check("acc_hold", acc, 255);
    check("acc_sat_sticky", acc_sat, 1);
    acc_en = 1'b0; in_valid = 1'b0; acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("acc_clr_value", acc, 0);
    check("acc_clr_sat", acc_sat, 0);

    // 5: clear coinciding with a valid count of 5 wins over accumulation.
    acc_en = 1'b1;
    in_valid = 1'b1; in_data = 15'h001F;
    step();
    step();
    in_valid = 1'b0; in_data = '0;
    step(); step(); step();
    check("clr_race_first_valid", out_valid, 1);
    check("clr_race_first_count", count, 5);
    step();
    check("clr_race_acc_before", acc, 5);
    check("clr_race_second_valid", out_valid, 1);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    $display("clr_race acc=%0d acc_sat=%0b", acc, acc_sat);
    check("clr_race_acc", acc, 0);
    check("clr_race_sat", acc_sat, 0);
    step();
    check("clr_race_acc_after", acc, 0);
    acc_en = 1'b0;

    // 6: alternating valid with a reset pulse mid-stream.
    for (int c = 0; c < 20; c++) begin
      rst      = (c == 5);
      in_valid = t6_v[c];
      in_data  = t6_d[c];
      step();
      $display("midrst c=%0d out_valid=%0b count=%0d ge=%0b", c, out_valid, count, ge_thresh);
      check("midrst_valid", out_valid, t6_eov[c]);
      check("midrst_count", count, t6_ecnt[c]);
      check("midrst_ge", ge_thresh, t6_ege[c]);
      check("midrst_acc", acc, 0);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
